// File: rtl/sw_debounce.sv
// sw_debounce: conditions WIDTH raw slide-switch inputs into clean levels.
// Each bit is synchronized through two flops and then debounced by its own
// counter; a new level is accepted once the synchronized input has differed
// from the current stable level for DEBOUNCE_CYCLES consecutive edges.
// Accepted changes produce one-cycle rise/fall pulses and a valid/ready
// event carrying a snapshot of the stable levels.
//
// Ports:
//   CLK100MHZ    in   clock, all state on rising edge
//   RESET        in   synchronous, active-high reset
//   SW           in   raw asynchronous switch levels [WIDTH]
//   SW_STABLE    out  debounced switch levels [WIDTH]
//   SW_RISE      out  one-cycle pulse per accepted 0->1 [WIDTH]
//   SW_FALL      out  one-cycle pulse per accepted 1->0 [WIDTH]
//   EVT_VALID    out  change event pending
//   EVT_DATA     out  SW_STABLE snapshot for the pending event [WIDTH]
//   EVT_READY    in   consumer takes the event when high with EVT_VALID
//   EVT_OVERRUN  out  sticky: a pending event was overwritten before accept
module sw_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK100MHZ,
  input  logic             RESET,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_STABLE,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             EVT_VALID,
  output logic [WIDTH-1:0] EVT_DATA,
  input  logic             EVT_READY,
  output logic             EVT_OVERRUN
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic             evt_overrun_q, evt_overrun_d;
  logic             change;

  always_comb begin
    sync1_d  = SW;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // Counter runs only while the synchronized level disagrees with the
      // stable level; reaching CNT_LAST accepts instead of incrementing,
      // so the counter never exceeds CNT_LAST.
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          rise_d[i]   = sync2_q[i];
          fall_d[i]   = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    change        = (stable_d != stable_q);
    evt_valid_d   = evt_valid_q;
    evt_data_d    = evt_data_q;
    evt_overrun_d = evt_overrun_q;
    if (change) begin
      // A new change always wins; it counts as an overrun only when the
      // pending event is not being taken on this same edge.
      evt_valid_d = 1'b1;
      evt_data_d  = stable_d;
      if (evt_valid_q && !EVT_READY) begin
        evt_overrun_d = 1'b1;
      end
    end else if (evt_valid_q && EVT_READY) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      cnt_q         <= '{default: '0};
      evt_valid_q   <= 1'b0;
      evt_data_q    <= '0;
      evt_overrun_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      cnt_q         <= cnt_d;
      evt_valid_q   <= evt_valid_d;
      evt_data_q    <= evt_data_d;
      evt_overrun_q <= evt_overrun_d;
    end
  end

  assign SW_STABLE   = stable_q;
  assign SW_RISE     = rise_q;
  assign SW_FALL     = fall_q;
  assign EVT_VALID   = evt_valid_q;
  assign EVT_DATA    = evt_data_q;
  assign EVT_OVERRUN = evt_overrun_q;

endmodule

// File: tb/tb_sw_debounce.sv
module tb_sw_debounce;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] sw_stable;
  logic [15:0] sw_rise;
  logic [15:0] sw_fall;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic        evt_ready;
  logic        evt_overrun;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  sw_debounce #(
    .WIDTH          (16),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLK100MHZ  (clk),
    .RESET      (rst),
    .SW         (sw),
    .SW_STABLE  (sw_stable),
    .SW_RISE    (sw_rise),
    .SW_FALL    (sw_fall),
    .EVT_VALID  (evt_valid),
    .EVT_DATA   (evt_data),
    .EVT_READY  (evt_ready),
    .EVT_OVERRUN(evt_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus and sampling both happen at falling edges; each tick spans
  // exactly one rising edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw = 16'h0000;
    evt_ready = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 16'hFFFF;
    evt_ready = 1'b1;
    tick(3);
    total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL reset_stable got %h exp %h", sw_stable, 16'h0000); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'h0000) $display("FAIL reset_rise got %h exp %h", sw_rise, 16'h0000); else pass_cnt++;
    total_cnt++; if (sw_fall !== 16'h0000) $display("FAIL reset_fall got %h exp %h", sw_fall, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL reset_valid got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (evt_data !== 16'h0000) $display("FAIL reset_data got %h exp %h", evt_data, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b0) $display("FAIL reset_overrun got %b exp %b", evt_overrun, 1'b0); else pass_cnt++;
    rst = 1'b0;
    sw = 16'h0000;
    evt_ready = 1'b0;
    tick(8);
    total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL idle_stable got %h exp %h", sw_stable, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL idle_valid got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
  endtask

  task automatic test_basic();
    do_reset();
    sw = 16'h0001;
    tick(5);
    total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL basic_early got %h exp %h", sw_stable, 16'h0000); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_stable !== 16'h0001) $display("FAIL basic_stable got %h exp %h", sw_stable, 16'h0001); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'h0001) $display("FAIL basic_rise got %h exp %h", sw_rise, 16'h0001); else pass_cnt++;
    total_cnt++; if (sw_fall !== 16'h0000) $display("FAIL basic_fall got %h exp %h", sw_fall, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b1) $display("FAIL basic_valid got %b exp %b", evt_valid, 1'b1); else pass_cnt++;
    total_cnt++; if (evt_data !== 16'h0001) $display("FAIL basic_data got %h exp %h", evt_data, 16'h0001); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_rise !== 16'h0000) $display("FAIL basic_rise_clr got %h exp %h", sw_rise, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b1) $display("FAIL basic_valid_hold got %b exp %b", evt_valid, 1'b1); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b0) $display("FAIL basic_overrun got %b exp %b", evt_overrun, 1'b0); else pass_cnt++;
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL basic_accept got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      sw = 16'h0008;
      tick(3);
      sw = 16'h0000;
      tick(3);
      total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL glitch_stable_%0d got %h exp %h", k, sw_stable, 16'h0000); else pass_cnt++;
      total_cnt++; if (evt_valid !== 1'b0) $display("FAIL glitch_valid_%0d got %b exp %b", k, evt_valid, 1'b0); else pass_cnt++;
    end
    total_cnt++; if (sw_rise !== 16'h0000) $display("FAIL glitch_rise got %h exp %h", sw_rise, 16'h0000); else pass_cnt++;
    // A four-cycle pulse is just long enough to be accepted.
    sw = 16'h0008;
    tick(4);
    sw = 16'h0000;
    tick(2);
    total_cnt++; if (sw_stable !== 16'h0008) $display("FAIL pulse4_stable got %h exp %h", sw_stable, 16'h0008); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'h0008) $display("FAIL pulse4_rise got %h exp %h", sw_rise, 16'h0008); else pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    sw = 16'h0010;
    tick(6);
    total_cnt++; if (evt_data !== 16'h0010) $display("FAIL ovr_first_data got %h exp %h", evt_data, 16'h0010); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b0) $display("FAIL ovr_first_flag got %b exp %b", evt_overrun, 1'b0); else pass_cnt++;
    sw = 16'h0030;
    tick(6);
    total_cnt++; if (evt_data !== 16'h0030) $display("FAIL ovr_data got %h exp %h", evt_data, 16'h0030); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b1) $display("FAIL ovr_valid got %b exp %b", evt_valid, 1'b1); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b1) $display("FAIL ovr_flag got %b exp %b", evt_overrun, 1'b1); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'h0020) $display("FAIL ovr_rise got %h exp %h", sw_rise, 16'h0020); else pass_cnt++;
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL ovr_accept got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b1) $display("FAIL ovr_sticky got %b exp %b", evt_overrun, 1'b1); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    sw = 16'h0010;
    tick(6);
    sw = 16'h0030;
    tick(5);
    total_cnt++; if (evt_data !== 16'h0010) $display("FAIL b2b_hold_data got %h exp %h", evt_data, 16'h0010); else pass_cnt++;
    evt_ready = 1'b1;
    tick(1);
    total_cnt++; if (evt_valid !== 1'b1) $display("FAIL b2b_valid got %b exp %b", evt_valid, 1'b1); else pass_cnt++;
    total_cnt++; if (evt_data !== 16'h0030) $display("FAIL b2b_data got %h exp %h", evt_data, 16'h0030); else pass_cnt++;
    total_cnt++; if (evt_overrun !== 1'b0) $display("FAIL b2b_overrun got %b exp %b", evt_overrun, 1'b0); else pass_cnt++;
    tick(1);
    evt_ready = 1'b0;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL b2b_drain got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sw = 16'hFFFF;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL rmid_stable got %h exp %h", sw_stable, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b0) $display("FAIL rmid_valid got %b exp %b", evt_valid, 1'b0); else pass_cnt++;
    tick(5);
    total_cnt++; if (sw_stable !== 16'h0000) $display("FAIL rmid_early got %h exp %h", sw_stable, 16'h0000); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_stable !== 16'hFFFF) $display("FAIL rmid_accept got %h exp %h", sw_stable, 16'hFFFF); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'hFFFF) $display("FAIL rmid_rise got %h exp %h", sw_rise, 16'hFFFF); else pass_cnt++;
    total_cnt++; if (evt_data !== 16'hFFFF) $display("FAIL rmid_data got %h exp %h", evt_data, 16'hFFFF); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_rise !== 16'h0000) $display("FAIL rmid_rise_clr got %h exp %h", sw_rise, 16'h0000); else pass_cnt++;
  endtask

  task automatic test_fall();
    do_reset();
    sw = 16'h00FF;
    tick(6);
    total_cnt++; if (sw_stable !== 16'h00FF) $display("FAIL fall_setup got %h exp %h", sw_stable, 16'h00FF); else pass_cnt++;
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    sw = 16'h0000;
    tick(5);
    total_cnt++; if (sw_fall !== 16'h0000) $display("FAIL fall_early got %h exp %h", sw_fall, 16'h0000); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_fall !== 16'h00FF) $display("FAIL fall_pulse got %h exp %h", sw_fall, 16'h00FF); else pass_cnt++;
    total_cnt++; if (sw_rise !== 16'h0000) $display("FAIL fall_rise got %h exp %h", sw_rise, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_data !== 16'h0000) $display("FAIL fall_data got %h exp %h", evt_data, 16'h0000); else pass_cnt++;
    total_cnt++; if (evt_valid !== 1'b1) $display("FAIL fall_valid got %b exp %b", evt_valid, 1'b1); else pass_cnt++;
    tick(1);
    total_cnt++; if (sw_fall !== 16'h0000) $display("FAIL fall_clr got %h exp %h", sw_fall, 16'h0000); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    sw        = 16'h0000;
    evt_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_fall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
- Parameters
  - REQ-001: The block SHALL take parameter WIDTH, default 16, giving the number of slide switches conditioned.
  - REQ-002: The block SHALL take parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), giving the clock cycles a synchronized input must hold a new level before acceptance; legal range >= 1.
- Ports
  - REQ-003: CLK100MHZ  input  1  the only clock; all state updates on its rising edge.
  - REQ-004: RESET  input  1  synchronous, active-high reset.
  - REQ-005: SW  input  WIDTH  raw asynchronous slide-switch levels.
  - REQ-006: SW_STABLE  output  WIDTH  debounced switch levels, registered.
  - REQ-007: SW_RISE  output  WIDTH  one-cycle pulse per bit on accepted 0->1.
  - REQ-008: SW_FALL  output  WIDTH  one-cycle pulse per bit on accepted 1->0.
  - REQ-009: EVT_VALID  output  1  change event pending for the consumer.
  - REQ-010: EVT_DATA  output  WIDTH  SW_STABLE snapshot for the pending event.
  - REQ-011: EVT_READY  input  1  consumer accepts the event when high with EVT_VALID.
  - REQ-012: EVT_OVERRUN  output  1  sticky flag: an unaccepted event was overwritten.

Function
- Synchronizer and debounce
  - REQ-013: Each SW bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
  - REQ-014: Each bit SHALL have an independent counter of width $clog2(DEBOUNCE_CYCLES+1).
  - REQ-015: Counter update per bit: if sync2 equals SW_STABLE, clear to 0; otherwise increment.
  - REQ-016: When sync2 differs from SW_STABLE and the counter equals DEBOUNCE_CYCLES-1, that bit of SW_STABLE SHALL take sync2 on that edge and the counter SHALL clear.
  - REQ-017: Any glitch returning sync2 to SW_STABLE before acceptance SHALL clear the counter, with no output change.
  - REQ-018: An SW change held steady SHALL appear on SW_STABLE exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
  - REQ-019: The counter SHALL never wrap; it cannot exceed DEBOUNCE_CYCLES-1.
- Edge pulses
  - REQ-020: SW_RISE[i]/SW_FALL[i] SHALL be high for exactly the single cycle in which SW_STABLE[i] first shows the new level; otherwise low.
  - REQ-021: Multiple bits accepted on the same edge SHALL pulse together.
- Event handshake
  - REQ-022: On the edge where any SW_STABLE bit changes, EVT_VALID SHALL go to 1 and EVT_DATA SHALL load the new SW_STABLE value.
  - REQ-023: Acceptance occurs on an edge with EVT_VALID=1 and EVT_READY=1; EVT_VALID then clears unless a new change occurs on that same edge.
  - REQ-024: Simultaneous acceptance and new change: EVT_VALID SHALL stay 1, EVT_DATA SHALL load the new value, and EVT_OVERRUN SHALL be unaffected.
  - REQ-025: New change while EVT_VALID=1 and EVT_READY=0: EVT_DATA SHALL be overwritten, EVT_VALID SHALL stay 1, and EVT_OVERRUN SHALL set.
  - REQ-026: EVT_OVERRUN SHALL clear only on reset.
  - REQ-027: EVT_DATA SHALL hold steady while EVT_VALID=1, except as in REQ-024/REQ-025.

Reset
- REQ-028: On an edge with RESET=1 the block SHALL clear sync flops, counters, SW_STABLE, SW_RISE, SW_FALL, EVT_VALID, EVT_DATA and EVT_OVERRUN to 0.
- REQ-029: Reset mid-debounce SHALL discard partial counts; switches held high at reset release SHALL be accepted after DEBOUNCE_CYCLES+2 edges and SHALL generate a rise pulse and an event.
- REQ-030: RESET SHALL take priority over all other inputs on the same edge.

Verification (DEBOUNCE_CYCLES=4, WIDTH=16)
- REQ-031: After reset, SW=16'h0001 held -> SW_STABLE=16'h0001 on edge 6 after first sample; SW_RISE=16'h0001 for one cycle; EVT_VALID=1 with EVT_DATA=16'h0001.
- REQ-032: SW[3] toggles 0->1->0 with 3-cycle high pulses, repeated 5 times -> SW_STABLE, SW_RISE and EVT_VALID remain 0.
- REQ-033: EVT_READY=0; SW 16'h0000->16'h0010, then ->16'h0030 after acceptance -> EVT_DATA=16'h0030, EVT_VALID=1, EVT_OVERRUN=1.
- REQ-034: EVT_READY held 1 while bit 5 is accepted on the same edge the prior event is taken -> EVT_VALID stays 1, EVT_DATA holds new value, EVT_OVERRUN=0.
- REQ-035: SW=16'hFFFF with RESET asserted at counter=2 for one cycle -> all outputs 0 that cycle; SW_STABLE=16'hFFFF on edge 6 after release; SW_RISE=16'hFFFF for one cycle.
- REQ-036: SW 16'h00FF->16'h0000 held -> SW_FALL=16'h00FF for exactly one cycle, SW_RISE=0, EVT_DATA=16'h0000.
